// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - multiply/divide unit shared encodings, states and latencies
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } mdOp_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } mdState_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

endpackage

// File: rtl/md_if.sv
// rtl/md_if.sv - E-stage multiply/divide request and HI/LO result bundle
interface md_if;

    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op, src_a, src_b, md_use_d,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  md_op, src_a, src_b, md_use_d,
        output busy, md_stall, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational product, quotient, remainder and divide-by-zero flag
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] resHi,
    output logic [31:0] resLo,
    output logic        divZero
);

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisorS;
    logic [31:0] divisorU;
    logic [31:0] magQ;
    logic [31:0] magR;
    logic [31:0] quotS;
    logic [31:0] remS;
    logic [31:0] quotU;
    logic [31:0] remU;
    logic        isDiv;

    assign prodS = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign prodU = {32'd0, srcA} * {32'd0, srcB};

    // Signed divide on magnitudes: -0x80000000 stays 0x80000000 as an unsigned
    // magnitude, so MIN / -1 wraps to MIN with no special case.
    assign magA     = srcA[31] ? (32'd0 - srcA) : srcA;
    assign magB     = srcB[31] ? (32'd0 - srcB) : srcB;
    assign divisorS = (srcB == 32'd0) ? 32'd1 : magB;
    assign divisorU = (srcB == 32'd0) ? 32'd1 : srcB;
    assign magQ     = magA / divisorS;
    assign magR     = magA % divisorS;
    assign quotS    = (srcA[31] ^ srcB[31]) ? (32'd0 - magQ) : magQ;
    assign remS     = srcA[31] ? (32'd0 - magR) : magR;
    assign quotU    = srcA / divisorU;
    assign remU     = srcA % divisorU;

    assign isDiv   = (op == MD_DIV) || (op == MD_DIVU);
    assign divZero = isDiv && (srcB == 32'd0);

    always_comb begin
        resHi = 32'd0;
        resLo = 32'd0;
        case (op)
            MD_MULT:  begin resHi = prodS[63:32]; resLo = prodS[31:0]; end
            MD_MULTU: begin resHi = prodU[63:32]; resLo = prodU[31:0]; end
            MD_DIV:   begin resHi = remS;         resLo = quotS;       end
            MD_DIVU:  begin resHi = remU;         resLo = quotU;       end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multicycle multiply/divide FSM with HI/LO registers and stall request
module md_unit
    import md_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    md_if.slave   mdBus
);

    mdState_e    state;
    mdState_e    nextState;
    logic [3:0]  count;
    logic [3:0]  nextCount;
    logic        capture;
    logic        commit;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] tempHi;
    logic [31:0] tempLo;
    logic        tempDivZero;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] arithHi;
    logic [31:0] arithLo;
    logic        arithDivZero;
    logic        isMulDiv;

    md_arith uArith (
        .op      (mdBus.md_op),
        .srcA    (mdBus.src_a),
        .srcB    (mdBus.src_b),
        .resHi   (arithHi),
        .resLo   (arithLo),
        .divZero (arithDivZero)
    );

    assign isMulDiv = (mdBus.md_op == MD_MULT) || (mdBus.md_op == MD_MULTU) ||
                      (mdBus.md_op == MD_DIV)  || (mdBus.md_op == MD_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    always_comb begin
        nextState = state;
        nextCount = count;
        capture   = 1'b0;
        commit    = 1'b0;
        writeHi   = 1'b0;
        writeLo   = 1'b0;
        case (state)
            IDLE: begin
                case (mdBus.md_op)
                    MD_MULT, MD_MULTU: begin
                        nextState = MUL_RUN;
                        nextCount = MUL_CYCLES;
                        capture   = 1'b1;
                    end
                    MD_DIV, MD_DIVU: begin
                        nextState = DIV_RUN;
                        nextCount = DIV_CYCLES;
                        capture   = 1'b1;
                    end
                    MD_MTHI: writeHi = 1'b1;
                    MD_MTLO: writeLo = 1'b1;
                    default: ;
                endcase
            end
            MUL_RUN, DIV_RUN: begin
                // Requests arriving here are dropped; only the countdown advances.
                if (count == 4'd1) begin
                    nextState = IDLE;
                    nextCount = 4'd0;
                    commit    = 1'b1;
                end else begin
                    nextCount = count - 4'd1;
                end
            end
            default: begin
                nextState = IDLE;
                nextCount = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempHi      <= 32'd0;
            tempLo      <= 32'd0;
            tempDivZero <= 1'b0;
            hiReg       <= 32'd0;
            loReg       <= 32'd0;
        end else begin
            if (capture) begin
                tempHi      <= arithHi;
                tempLo      <= arithLo;
                tempDivZero <= arithDivZero;
            end
            if (commit && !tempDivZero) begin
                hiReg <= tempHi;
                loReg <= tempLo;
            end
            if (writeHi) hiReg <= mdBus.src_a;
            if (writeLo) loReg <= mdBus.src_a;
        end
    end

    assign mdBus.busy     = (state != IDLE);
    assign mdBus.md_stall = rst_n & mdBus.md_use_d & (mdBus.busy | isMulDiv);
    assign mdBus.hi       = hiReg;
    assign mdBus.lo       = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against a transaction-level model
module tb_md_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] refHi;
    logic [31:0] refLo;

    md_if mdBus ();

    md_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdBus (mdBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one request: new HI/LO and how many busy cycles it costs.
    function automatic void refOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int cycles);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cycles = 0;
        case (op)
            3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; cycles = 5; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; cycles = 5; end
            3'd3: begin
                cycles = 10;
                if (b != 0) begin
                    p = 64'(sa / sb); l = p[31:0];
                    p = 64'(sa % sb); h = p[31:0];
                end
            end
            3'd4: begin
                cycles = 10;
                if (b != 0) begin l = a / b; h = a % b; end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic useD);
        logic [31:0] newHi;
        logic [31:0] newLo;
        int          n;
        logic        isMD;
        logic        ud;
        newHi = refHi;
        newLo = refLo;
        refOp(op, a, b, newHi, newLo, n);
        isMD = (op >= 3'd1) && (op <= 3'd4);

        @(posedge clk); #1;
        mdBus.md_op = op; mdBus.src_a = a; mdBus.src_b = b; mdBus.md_use_d = useD;
        @(negedge clk);
        checkVal("stall_issue", 32'(mdBus.md_stall), 32'(useD & isMD));
        checkVal("busy_issue", 32'(mdBus.busy), 32'd0);

        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            ud = useD ? 1'b1 : 1'($urandom_range(0, 1));
            mdBus.md_op    = (i == 2) ? 3'd1 : 3'($urandom_range(1, 7));
            mdBus.src_a    = $urandom;
            mdBus.src_b    = $urandom;
            mdBus.md_use_d = ud;
            @(negedge clk);
            checkVal("busy_run", 32'(mdBus.busy), 32'd1);
            checkVal("stall_run", 32'(mdBus.md_stall), 32'(ud));
            checkVal("hi_run", mdBus.hi, refHi);
            checkVal("lo_run", mdBus.lo, refLo);
        end

        @(posedge clk); #1;
        mdBus.md_op = 3'd0; mdBus.md_use_d = 1'b1;
        @(negedge clk);
        checkVal("busy_done", 32'(mdBus.busy), 32'd0);
        checkVal("stall_done", 32'(mdBus.md_stall), 32'd0);
        checkVal("hi_done", mdBus.hi, newHi);
        checkVal("lo_done", mdBus.lo, newLo);
        refHi = newHi;
        refLo = newLo;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        total = 0;
        bad   = 0;
        refHi = 32'd0;
        refLo = 32'd0;

        rst_n = 1'b0;
        mdBus.md_op = 3'd1; mdBus.src_a = 32'd5; mdBus.src_b = 32'd7; mdBus.md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("rst_busy", 32'(mdBus.busy), 32'd0);
        checkVal("rst_stall", 32'(mdBus.md_stall), 32'd0);
        checkVal("rst_hi", mdBus.hi, 32'd0);
        checkVal("rst_lo", mdBus.lo, 32'd0);
        mdBus.md_op = 3'd0; mdBus.md_use_d = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        runOp(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        checkVal("mult_neg_hi", mdBus.hi, 32'hFFFF_FFFF);
        checkVal("mult_neg_lo", mdBus.lo, 32'hFFFF_FFFA);
        runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkVal("multu_hi", mdBus.hi, 32'hFFFF_FFFE);
        checkVal("multu_lo", mdBus.lo, 32'h0000_0001);
        runOp(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        checkVal("div_neg_hi", mdBus.hi, 32'hFFFF_FFFF);
        checkVal("div_neg_lo", mdBus.lo, 32'hFFFF_FFFD);
        runOp(3'd3, 32'd1234, 32'd0, 1'b0);
        checkVal("div0_hi", mdBus.hi, 32'hFFFF_FFFF);
        checkVal("div0_lo", mdBus.lo, 32'hFFFF_FFFD);
        runOp(3'd5, 32'h1234_5678, 32'd0, 1'b1);
        checkVal("mthi_hi", mdBus.hi, 32'h1234_5678);
        runOp(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
        runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        checkVal("div_min_hi", mdBus.hi, 32'd0);
        checkVal("div_min_lo", mdBus.lo, 32'h8000_0000);
        runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runOp(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1);

        for (int k = 0; k < 80; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            runOp(op, a, b, 1'($urandom_range(0, 1)));
        end

        // Abort a divide with an asynchronous reset in its third busy cycle.
        runOp(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
        @(posedge clk); #1;
        mdBus.md_op = 3'd3; mdBus.src_a = 32'd100; mdBus.src_b = 32'd7; mdBus.md_use_d = 1'b0;
        @(posedge clk); #1;
        mdBus.md_op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; mdBus.md_op = 3'd1; mdBus.md_use_d = 1'b1;
        #1;
        checkVal("abort_busy", 32'(mdBus.busy), 32'd0);
        checkVal("abort_hi", mdBus.hi, 32'd0);
        checkVal("abort_lo", mdBus.lo, 32'd0);
        @(negedge clk);
        checkVal("abort_stall", 32'(mdBus.md_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mdBus.md_op = 3'd0; mdBus.md_use_d = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checkVal("post_abort_busy", 32'(mdBus.busy), 32'd0);
            checkVal("post_abort_hi", mdBus.hi, 32'd0);
            checkVal("post_abort_lo", mdBus.lo, 32'd0);
        end
        refHi = 32'd0;
        refLo = 32'd0;
        runOp(3'd1, 32'd7, 32'hFFFF_FFFF, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
